frame_tx: RTL and testbench
===========================

// Module: frame_tx
// PURPOSE
//   Return path to the host: on a one-cycle start request, serialises a fixed frame
//   over a UART TX line (8N1, LSB first).
//   Frame = HEADER byte, then N_BYTES register bytes read via rd_idx/rd_data
//   (idx 0..N_BYTES-1), then an XOR checksum byte.
//   Sits beside the UART receive/register-update path; reads the same register bank.
// PARAMETERS
//   CLKS_PER_BIT  217    clk cycles per UART bit (>=4)
//   N_BYTES       3      register bytes per frame (1..55)
//   HEADER        8'hA5  first byte of every frame
// PORTS
//   clk      in   1  system clock
//   reset    in   1  synchronous, active-high reset
//   start    in   1  request a frame; sampled only in IDLE
//   rd_idx   out  6  register index being fetched (0..N_BYTES-1)
//   rd_data  in   8  register byte for rd_idx; must be stable 2 cycles after rd_idx changes
//   tx       out  1  UART serial output, idle high
//   busy     out  1  high while a frame is in progress
//   done     out  1  one-cycle pulse when frame completes
// BEHAVIOUR
//   Reset: tx=1, busy=0, done=0, rd_idx=0, checksum=0, bit/baud counters=0, state=IDLE.
//   States: IDLE -> HDR -> DATA (xN_BYTES) -> CHK -> IDLE.
//   IDLE: tx=1, busy=0. If start=1 at cycle T: cycle T+1 busy=1, tx=0 (HDR start bit),
//     rd_idx=0, checksum cleared.
//   Byte timing: start bit(0), d0..d7, stop bit(1); each bit exactly CLKS_PER_BIT cycles;
//     one byte = 10*CLKS_PER_BIT cycles. No idle gap: the next start bit begins the cycle
//     after the previous stop bit's last cycle.
//   Fetch: rd_data is latched on the last cycle of each preceding stop bit (HDR stop bit
//     for idx 0, etc.). On the cycle after latching, checksum ^= latched byte and rd_idx
//     increments (saturates at N_BYTES-1; it holds after the last fetch).
//   CHK: sends checksum = XOR of the N_BYTES data bytes (HEADER excluded).
//   End: on the cycle after the CHK stop bit's last cycle: busy=0, done=1 (1 cycle),
//     state=IDLE, rd_idx=0. start is also sampled in this cycle.
//     If start=1 then, the next frame begins the following cycle.
//   Frame length: (N_BYTES+2)*10*CLKS_PER_BIT cycles from first start bit to done.
//   start while busy: ignored (not queued).
//   rd_data changes other than at the latch cycle: no effect on the frame.
//   Reset mid-frame (any state/bit): next cycle is the reset state. tx=1 immediately.
//     The partial byte is abandoned and done is not pulsed.
//   Counters: baud counter counts 0..CLKS_PER_BIT-1 then wraps; bit counter 0..9.
//     Widths are sized from the parameters.
// TESTING
//   Reset: assert reset 3 cycles -> tx=1, busy=0, done=0, rd_idx=0; stays so with start=0.
//   Basic frame (CLKS_PER_BIT=4, N_BYTES=3, regs {12,34,56}h), start pulse ->
//     tx decodes A5,12,34,56,70h.
//     busy high exactly 200 cycles; done pulses once at cycle 201.
//   Fetch timing: change reg0 from 12h to FFh one cycle after the HDR stop-bit latch ->
//     12h still sent.
//   Fetch timing: change reg0 before the latch cycle -> FFh sent.
//   Busy ignore: pulse start at cycles 50 and 150 of a frame -> only one frame; single done.
//   Reset mid-byte: assert reset during d3 of data byte 1 -> tx=1 next cycle, busy=0, no done.
//     A new start afterwards gives a correct full frame.
//   Back-to-back: hold start high -> second HDR start bit begins the cycle after done.
//     No extra idle bit; checksum restarts from 0.

Source files
------------

// File: rtl/frame_tx.sv
// UART (8N1, LSB first) frame transmitter: sends HEADER, N_BYTES register bytes fetched
// over rd_idx/rd_data, then the XOR of those register bytes, on a one-cycle start request.
module frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned N_BYTES      = 3,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [5:0] rd_idx,
    input  logic [7:0] rd_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned     BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [5:0]      LAST_IDX  = 6'(N_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CHK
    } state_t;

    state_t            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [3:0]        bit_q;
    logic [7:0]        byte_q;
    logic [7:0]        chk_q;
    logic [5:0]        idx_q;
    logic [5:0]        cnt_q;
    logic              fetch_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;

    logic              bit_end;
    logic [5:0]        idx_d;
    logic [7:0]        chk_d;

    assign bit_end = (baud_q == BAUD_LAST);
    assign idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 6'd1;
    assign chk_d   = chk_q ^ byte_q;

    // NOTE: all state lives in one clocked block and is assigned with <= only, so every
    // read in this block sees the value from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            chk_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            fetch_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Cycle after a latch: fold the new byte into the checksum and move the fetch on.
            if (fetch_q) begin
                chk_q   <= chk_d;
                idx_q   <= idx_d;
                fetch_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_HDR;
                        busy_q  <= 1'b1;
                        tx_q    <= 1'b0;
                        idx_q   <= '0;
                        chk_q   <= '0;
                        byte_q  <= HEADER;
                        baud_q  <= '0;
                        bit_q   <= '0;
                    end
                end
                default: begin
                    if (!bit_end) begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end else begin
                        baud_q <= '0;
                        if (bit_q != 4'd9) begin
                            bit_q <= bit_q + 4'd1;
                            tx_q  <= (bit_q < 4'd8) ? byte_q[bit_q[2:0]] : 1'b1;
                        end else begin
                            // Last cycle of a stop bit: the next start bit follows with no gap.
                            bit_q <= '0;
                            tx_q  <= 1'b0;
                            case (state_q)
                                S_HDR: begin
                                    state_q <= S_DATA;
                                    byte_q  <= rd_data;
                                    fetch_q <= 1'b1;
                                    cnt_q   <= '0;
                                end
                                S_DATA: begin
                                    if (cnt_q == LAST_IDX) begin
                                        state_q <= S_CHK;
                                        byte_q  <= chk_q;
                                    end else begin
                                        byte_q  <= rd_data;
                                        fetch_q <= 1'b1;
                                        cnt_q   <= cnt_q + 6'd1;
                                    end
                                end
                                default: begin
                                    state_q <= S_IDLE;
                                    tx_q    <= 1'b1;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    idx_q   <= '0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign rd_idx = idx_q;
    assign tx     = tx_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_frame_tx.sv
// Bench for frame_tx: a frame-position model checks tx/busy/done/rd_idx every cycle, and a
// UART decoder plus literal expectations pin the decoded bytes and the frame timing.
module tb_frame_tx;

    localparam int CPB       = 4;
    localparam int N         = 3;
    localparam int BYTE_LEN  = 10 * CPB;
    localparam int FRAME_LEN = (N + 2) * BYTE_LEN;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] rd_idx;
    logic [7:0] rd_data;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] regs [3];

    int n_checks = 0;
    int n_fail   = 0;

    frame_tx #(
        .CLKS_PER_BIT(CPB),
        .N_BYTES     (N),
        .HEADER      (8'hA5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .rd_idx (rd_idx),
        .rd_data(rd_data),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    assign rd_data = (rd_idx < 6'd3) ? regs[rd_idx[1:0]] : 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: position m_f (1..FRAME_LEN) within the frame decides every output.
    bit         m_valid = 1'b0;
    bit         m_busy  = 1'b0;
    bit         m_done  = 1'b0;
    int         m_f     = 0;
    logic [7:0] m_bytes [N + 2];

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_f     = 0;
        end else if (m_busy) begin
            if (m_f == FRAME_LEN) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_f    = 0;
            end else begin
                if (m_f % BYTE_LEN == 0 && m_f / BYTE_LEN >= 1 && m_f / BYTE_LEN <= N) begin
                    m_bytes[m_f / BYTE_LEN] = regs[m_f / BYTE_LEN - 1];
                    if (m_f / BYTE_LEN == N) begin
                        m_bytes[N + 1] = 8'h00;
                        for (int k = 1; k <= N; k++) m_bytes[N + 1] ^= m_bytes[k];
                    end
                end
                m_f++;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_busy     = 1'b1;
                m_f        = 1;
                m_bytes[0] = 8'hA5;
            end
        end
    end

    function automatic logic exp_tx();
        int b, n;
        if (!m_busy) return 1'b1;
        b = (m_f - 1) / BYTE_LEN;
        n = ((m_f - 1) % BYTE_LEN) / CPB;
        if (n == 0) return 1'b0;
        if (n == 9) return 1'b1;
        return m_bytes[b][n - 1];
    endfunction

    function automatic logic [5:0] exp_idx();
        int cnt = 0;
        if (!m_busy) return 6'd0;
        for (int k = 1; k <= N; k++) if (m_f >= k * BYTE_LEN + 2) cnt++;
        if (cnt > N - 1) cnt = N - 1;
        return 6'(cnt);
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("tx", 32'(tx), 32'(exp_tx()));
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("rd_idx", 32'(rd_idx), 32'(exp_idx()));
        end
    end

    // Independent UART receiver: samples mid-bit and queues each received byte.
    logic [7:0] rx_q [$];

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (m_valid && !reset && tx == 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    task automatic check_rx5(input string name, input logic [7:0] e0, e1, e2, e3, e4);
        logic [7:0] exp [5];
        exp = '{e0, e1, e2, e3, e4};
        for (int i = 0; i < 5; i++) begin
            if (rx_q.size() == 0) begin
                check({name, "_missing"}, 32'(i), 32'd5);
                return;
            end
            check(name, 32'(rx_q.pop_front()), 32'(exp[i]));
        end
    endtask

    // Per-cycle hooks applied while waiting for done (frame cycle numbers, -1 = unused).
    int         hk_s1 = -1, hk_s2 = -1, hk_chg = -1, hk_rst = -1;
    logic [7:0] hk_val = 8'h00;
    bit         hold_start = 1'b0;

    task automatic clear_hooks();
        hk_s1 = -1; hk_s2 = -1; hk_chg = -1; hk_rst = -1; hold_start = 1'b0;
    endtask

    // Called just after a negedge; cycle 1 is the first cycle after the caller's start.
    task automatic wait_done(input int max, output int busy_cycles, output int done_cycle);
        busy_cycles = 0;
        done_cycle  = 0;
        for (int cyc = 1; cyc <= max; cyc++) begin
            @(negedge clk);
            if (hk_rst >= 0 && cyc == hk_rst + 1) begin
                check("rst_tx", 32'(tx), 32'd1);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
            end
            if (busy) busy_cycles++;
            if (done) begin
                done_cycle = cyc;
                break;
            end
            #1;
            start = (cyc == hk_s1) || (cyc == hk_s2) || hold_start;
            reset = (cyc == hk_rst);
            if (cyc == hk_chg) regs[0] = hk_val;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic basic_frame(input string name, input logic [7:0] d0, input logic [7:0] ck);
        int bc, dc;
        rx_q.delete();
        #1 start = 1'b1;
        wait_done(400, bc, dc);
        check({name, "_done_cycle"}, 32'(dc), 32'd201);
        @(negedge clk);
        check({name, "_done_width"}, 32'(done), 32'd0);
        check_rx5(name, 8'hA5, d0, 8'h34, 8'h56, ck);
        clear_hooks();
        regs[0] = 8'h12;
        idle(5);
    endtask

    initial begin
        int bc, dc, seen;
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, dc, seen;
        reset   = 1'b1;
        start   = 1'b0;
        regs[0] = 8'h12;
        regs[1] = 8'h34;
        regs[2] = 8'h56;

        // Reset held for 3 cycles, then idle with start low.
        idle(3);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_idx", 32'(rd_idx), 32'd0);
        #1 reset = 1'b0;
        idle(10);
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic frame: busy exactly 200 cycles, done at cycle 201.
        rx_q.delete();
        #1 start = 1'b1;
        wait_done(400, bc, dc);
        check("basic_busy_cycles", 32'(bc), 32'd200);
        check("basic_done_cycle", 32'(dc), 32'd201);
        @(negedge clk);
        check("basic_done_width", 32'(done), 32'd0);
        check_rx5("basic_rx", 8'hA5, 8'h12, 8'h34, 8'h56, 8'h70);
        idle(5);

        // reg0 changed the cycle after the HDR stop-bit latch: old value is sent.
        hk_chg = 41; hk_val = 8'hFF;
        basic_frame("late_chg", 8'h12, 8'h70);

        // reg0 changed before the latch: new value is sent and checksummed.
        hk_chg = 38; hk_val = 8'hFF;
        basic_frame("early_chg", 8'hFF, 8'h9D);

        // start pulses while busy are ignored.
        hk_s1 = 50; hk_s2 = 150;
        basic_frame("busy_ign", 8'h12, 8'h70);
        seen = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        check("busy_ign_no_second", 32'(seen), 32'd0);

        // Reset during d3 of the second data byte: frame abandoned, no done.
        rx_q.delete();
        hk_rst = 98;
        #1 start = 1'b1;
        wait_done(300, bc, dc);
        check("midrst_no_done", 32'(dc), 32'd0);
        clear_hooks();
        idle(5);
        basic_frame("after_rst", 8'h12, 8'h70);

        // Back-to-back with start held: next start bit right after done, checksum restarts.
        rx_q.delete();
        hold_start = 1'b1;
        #1 start = 1'b1;
        wait_done(400, bc, dc);
        check("b2b_done1", 32'(dc), 32'd201);
        @(negedge clk);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_tx", 32'(tx), 32'd0);
        #1;
        hold_start = 1'b0;
        start = 1'b0;
        wait_done(400, bc, dc);
        check("b2b_done2", 32'(dc), 32'd200);
        check_rx5("b2b_rx1", 8'hA5, 8'h12, 8'h34, 8'h56, 8'h70);
        check_rx5("b2b_rx2", 8'hA5, 8'h12, 8'h34, 8'h56, 8'h70);
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
